// File: rtl/teclado_pkg.sv
// Shared types and constants for the keypad scanner: FSM state encoding,
// default geometry/timing values and a 4x4 code to hex-digit helper.
package teclado_pkg;

  // Scanner states
  typedef enum logic [1:0] {
    ESCANEO    = 2'd0,
    REBOTE     = 2'd1,
    PRESIONADA = 2'd2,
    LIBERACION = 2'd3
  } estado_t;

  // Default geometry and timing
  localparam int N_FILAS_DEF       = 4;
  localparam int N_COLS_DEF        = 4;
  localparam int CICLOS_COL_DEF    = 1000;
  localparam int CICLOS_REBOTE_DEF = 100000;

  // Maps a 4x4 key code (fila*4 + col) to the digit printed on the key.
  // Layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D, with * = E and # = F.
  function automatic logic [3:0] codigo_a_hex(input logic [3:0] codigo);
    logic [3:0] hex;
    case (codigo)
      4'd0:    hex = 4'h1;
      4'd1:    hex = 4'h2;
      4'd2:    hex = 4'h3;
      4'd3:    hex = 4'hA;
      4'd4:    hex = 4'h4;
      4'd5:    hex = 4'h5;
      4'd6:    hex = 4'h6;
      4'd7:    hex = 4'hB;
      4'd8:    hex = 4'h7;
      4'd9:    hex = 4'h8;
      4'd10:   hex = 4'h9;
      4'd11:   hex = 4'hC;
      4'd12:   hex = 4'hE;
      4'd13:   hex = 4'h0;
      4'd14:   hex = 4'hF;
      default: hex = 4'hD;
    endcase
    return hex;
  endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer for a bus of asynchronous inputs. Resets to all ones
// so an idle (active-low, released) keypad is seen while reset is applied.
module sincronizador #(
  parameter int ANCHO = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ANCHO-1:0] d,
  output logic [ANCHO-1:0] q
);

  logic [ANCHO-1:0] meta_reg;
  logic [ANCHO-1:0] sinc_reg;

  // Two register stages; the first may go metastable, the second settles it.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= '1;
      sinc_reg <= '1;
    end else begin
      meta_reg <= d;
      sinc_reg <= meta_reg;
    end
  end

  assign q = sinc_reg;

endmodule

// File: rtl/escaner_teclado.sv
// Matrix keypad scanner: drives one column low at a time, debounces a single
// pressed key, reports one code per press and flags codes lost to overflow.
module escaner_teclado
  import teclado_pkg::*;
#(
  parameter int N_FILAS       = N_FILAS_DEF,
  parameter int N_COLS        = N_COLS_DEF,
  parameter int CICLOS_COL    = CICLOS_COL_DEF,
  parameter int CICLOS_REBOTE = CICLOS_REBOTE_DEF,
  localparam int CODE_W       = $clog2(N_FILAS * N_COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_FILAS-1:0] filas,
  output logic [N_COLS-1:0]  columnas,
  output logic [CODE_W-1:0]  tecla,
  output logic              tecla_valida,
  input  logic              tecla_leida,
  output logic              presionada,
  output logic              desborde
);

  localparam int FILA_W = (N_FILAS > 1) ? $clog2(N_FILAS) : 1;
  localparam int COL_W  = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int CNTF_W = $clog2(N_FILAS + 1);
  localparam int CC_W   = $clog2(CICLOS_COL + 1);
  localparam int CR_W   = $clog2(CICLOS_REBOTE + 1);

  // The row sample is taken on the last dwell clock; shorter dwells would not
  // leave the synchronizer time to reflect the newly driven column.
  if (CICLOS_COL < 3) begin : g_ciclos_col_invalido
    $error("escaner_teclado: CICLOS_COL must be at least 3");
  end

  logic [N_FILAS-1:0] filas_s;

  estado_t            estado_reg, estado_next;
  logic [COL_W-1:0]   col_reg, col_next, col_sig;
  logic [FILA_W-1:0]  fila_reg, fila_next, fila_det;
  logic [N_FILAS-1:0] patron_reg, patron_next;
  logic [CC_W-1:0]    cnt_col_reg, cnt_col_next;
  logic [CR_W-1:0]    cnt_reb_reg, cnt_reb_next;
  logic [CODE_W-1:0]  tecla_reg, tecla_next, codigo_lat;
  logic               valida_reg, valida_next;
  logic               presionada_reg, presionada_next;
  logic               desborde_reg, desborde_next;
  logic [CNTF_W-1:0]  num_bajas;
  logic               una_baja, todas_altas, acepta;

  sincronizador #(
    .ANCHO(N_FILAS)
  ) u_sincronizador (
    .clk(clk),
    .rst(rst),
    .d  (filas),
    .q  (filas_s)
  );

  // Column drive: index 0 sits on the MSB, so scanning walks MSB-first.
  for (genvar gi = 0; gi < N_COLS; gi++) begin : g_columna
    assign columnas[gi] = (col_reg != COL_W'(N_COLS - 1 - gi));
  end

  // Count low rows and remember the index of the low one (MSB = row 0).
  always_comb begin
    num_bajas = '0;
    fila_det  = '0;
    for (int i = 0; i < N_FILAS; i++) begin
      if (!filas_s[i]) begin
        num_bajas = num_bajas + CNTF_W'(1);
        fila_det  = FILA_W'(N_FILAS - 1 - i);
      end
    end
  end

  assign una_baja    = (num_bajas == CNTF_W'(1));
  assign todas_altas = &filas_s;
  assign col_sig     = (col_reg == COL_W'(N_COLS - 1)) ? '0 : col_reg + COL_W'(1);
  assign codigo_lat  = CODE_W'(int'(fila_reg) * N_COLS + int'(col_reg));

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_reg     <= ESCANEO;
      col_reg        <= '0;
      fila_reg       <= '0;
      patron_reg     <= '1;
      cnt_col_reg    <= '0;
      cnt_reb_reg    <= '0;
      tecla_reg      <= '0;
      valida_reg     <= 1'b0;
      presionada_reg <= 1'b0;
      desborde_reg   <= 1'b0;
    end else begin
      estado_reg     <= estado_next;
      col_reg        <= col_next;
      fila_reg       <= fila_next;
      patron_reg     <= patron_next;
      cnt_col_reg    <= cnt_col_next;
      cnt_reb_reg    <= cnt_reb_next;
      tecla_reg      <= tecla_next;
      valida_reg     <= valida_next;
      presionada_reg <= presionada_next;
      desborde_reg   <= desborde_next;
    end
  end

  // Next-state logic: scan, debounce press, hold, debounce release; plus the
  // output handshake (valid/ack and overflow on an unread code).
  always_comb begin
    estado_next     = estado_reg;
    col_next        = col_reg;
    fila_next       = fila_reg;
    patron_next     = patron_reg;
    cnt_col_next    = cnt_col_reg;
    cnt_reb_next    = cnt_reb_reg;
    tecla_next      = tecla_reg;
    valida_next     = valida_reg;
    presionada_next = presionada_reg;
    desborde_next   = desborde_reg;
    acepta          = 1'b0;

    case (estado_reg)
      ESCANEO: begin
        if (cnt_col_reg == CC_W'(CICLOS_COL - 1)) begin
          cnt_col_next = '0;
          if (una_baja) begin
            // Keep the column driven and start debouncing this pattern.
            fila_next    = fila_det;
            patron_next  = filas_s;
            cnt_reb_next = '0;
            estado_next  = REBOTE;
          end else begin
            // Nothing pressed or a ghosting pattern: move on.
            col_next = col_sig;
          end
        end else begin
          cnt_col_next = cnt_col_reg + CC_W'(1);
        end
      end

      REBOTE: begin
        if (filas_s != patron_reg) begin
          estado_next  = ESCANEO;
          col_next     = col_sig;
          cnt_col_next = '0;
          cnt_reb_next = '0;
        end else if (cnt_reb_reg == CR_W'(CICLOS_REBOTE - 1)) begin
          acepta       = 1'b1;
          estado_next  = PRESIONADA;
          cnt_reb_next = '0;
        end else begin
          cnt_reb_next = cnt_reb_reg + CR_W'(1);
        end
      end

      PRESIONADA: begin
        if (todas_altas) begin
          estado_next  = LIBERACION;
          cnt_reb_next = '0;
        end
      end

      LIBERACION: begin
        if (!todas_altas) begin
          // Release was a bounce; the same press continues, no new code.
          estado_next  = PRESIONADA;
          cnt_reb_next = '0;
        end else if (cnt_reb_reg == CR_W'(CICLOS_REBOTE - 1)) begin
          estado_next     = ESCANEO;
          presionada_next = 1'b0;
          col_next        = col_sig;
          cnt_col_next    = '0;
          cnt_reb_next    = '0;
        end else begin
          cnt_reb_next = cnt_reb_reg + CR_W'(1);
        end
      end

      default: begin
        estado_next = ESCANEO;
      end
    endcase

    if (acepta) begin
      presionada_next = 1'b1;
      if (!valida_reg || tecla_leida) begin
        tecla_next  = codigo_lat;
        valida_next = 1'b1;
      end else begin
        desborde_next = 1'b1;
      end
    end else if (tecla_leida && valida_reg) begin
      valida_next = 1'b0;
    end
  end

  assign tecla        = tecla_reg;
  assign tecla_valida = valida_reg;
  assign presionada   = presionada_reg;
  assign desborde     = desborde_reg;

endmodule

// File: tb/tb_escaner_teclado.sv
// Testbench for escaner_teclado: a 4x4 keypad model closes the loop from
// columnas back to filas; scenarios are checked against keypad-level rules.
module tb_escaner_teclado;

  localparam int NF = 4;
  localparam int NC = 4;
  localparam int CC = 4;
  localparam int CR = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] filas;
  logic [3:0] columnas;
  logic [3:0] tecla;
  logic       tecla_valida;
  logic       tecla_leida;
  logic       presionada;
  logic       desborde;

  int checks = 0;
  int errors = 0;

  // Keypad model: pressed-key set, or a forced raw row pattern.
  logic [15:0] teclas;
  logic        forzar;
  logic [3:0]  filas_forz;

  int subidas = 0;
  logic valida_prev = 1'b0;

  escaner_teclado #(
    .N_FILAS      (NF),
    .N_COLS       (NC),
    .CICLOS_COL   (CC),
    .CICLOS_REBOTE(CR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .filas       (filas),
    .columnas    (columnas),
    .tecla       (tecla),
    .tecla_valida(tecla_valida),
    .tecla_leida (tecla_leida),
    .presionada  (presionada),
    .desborde    (desborde)
  );

  always #5 clk = ~clk;

  // A pressed key at (r,c) pulls row r low while column c is driven low.
  // Row r sits on bit 3-r, column c on bit 3-c.
  always_comb begin
    filas = 4'b1111;
    if (forzar) begin
      filas = filas_forz;
    end else begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (teclas[r*4 + c] && !columnas[3-c]) filas[3-r] = 1'b0;
    end
  end

  // Count rising edges of tecla_valida.
  always @(posedge clk) begin
    if (tecla_valida && !valida_prev) subidas = subidas + 1;
    valida_prev = tecla_valida;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; teclas = '0; forzar = 1'b0; filas_forz = 4'hF; tecla_leida = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Observes columnas for n cycles and summarises the scan behaviour.
  task automatic observar_barrido(input int n, output int mal_oh, output int mal_len,
                                  output int mal_orden, output int trans);
    logic [3:0] prev, esperado;
    int len, idx;
    mal_oh = 0; mal_len = 0; mal_orden = 0; trans = 0; len = 0;
    prev = columnas;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!$onehot(~columnas)) mal_oh++;
      if (columnas == prev) begin
        len++;
      end else begin
        if (trans > 0 && len != CC) mal_len++;
        idx = 0;
        for (int b = 0; b < 4; b++) if (!prev[b]) idx = 3 - b;
        idx = (idx + 1) % 4;
        esperado = ~(4'b1000 >> idx);
        if (columnas !== esperado) mal_orden++;
        trans++;
        prev = columnas;
        len = 1;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; teclas = 16'hFFFF; tecla_leida = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (columnas !== 4'b0111) begin errors++; $display("FAIL reset_columnas: got %b expected 0111", columnas); end
    checks++; if (tecla !== 4'd0) begin errors++; $display("FAIL reset_tecla: got %0d expected 0", tecla); end
    checks++; if (tecla_valida !== 1'b0) begin errors++; $display("FAIL reset_valida: got %b expected 0", tecla_valida); end
    checks++; if (presionada !== 1'b0) begin errors++; $display("FAIL reset_presionada: got %b expected 0", presionada); end
    checks++; if (desborde !== 1'b0) begin errors++; $display("FAIL reset_desborde: got %b expected 0", desborde); end
    $display("test_reset: columnas=%b tecla=%0d valida=%b", columnas, tecla, tecla_valida);
    do_reset();
  endtask

  task automatic test_scan();
    int oh, ln, ord, tr;
    do_reset();
    observar_barrido(40, oh, ln, ord, tr);
    checks++; if (oh != 0) begin errors++; $display("FAIL scan_onehot: got %0d bad cycles expected 0", oh); end
    checks++; if (ln != 0) begin errors++; $display("FAIL scan_dwell: got %0d bad dwells expected 0", ln); end
    checks++; if (ord != 0) begin errors++; $display("FAIL scan_order: got %0d bad steps expected 0", ord); end
    checks++; if (tr < 9) begin errors++; $display("FAIL scan_progress: got %0d steps expected >=9", tr); end
    $display("test_scan: steps=%0d", tr);
  endtask

  task automatic test_basic();
    int k;
    do_reset();
    teclas[6] = 1'b1;
    for (k = 0; k < 200; k++) begin @(negedge clk); if (presionada) break; end
    checks++; if (presionada !== 1'b1) begin errors++; $display("FAIL basic_press: got presionada=%b expected 1", presionada); end
    checks++; if (tecla !== 4'd6) begin errors++; $display("FAIL basic_tecla: got %0d expected 6", tecla); end
    checks++; if (tecla_valida !== 1'b1) begin errors++; $display("FAIL basic_valida: got %b expected 1", tecla_valida); end
    checks++; if (columnas !== 4'b1101) begin errors++; $display("FAIL basic_columna: got %b expected 1101", columnas); end
    tecla_leida = 1'b1;
    @(negedge clk);
    tecla_leida = 1'b0;
    checks++; if (tecla_valida !== 1'b0) begin errors++; $display("FAIL basic_ack: got %b expected 0", tecla_valida); end
    teclas = '0;
    for (k = 0; k < 200; k++) begin @(negedge clk); if (!presionada) break; end
    checks++; if (presionada !== 1'b0) begin errors++; $display("FAIL basic_release: got %b expected 0", presionada); end
    repeat (30) @(negedge clk);
    checks++; if (tecla_valida !== 1'b0) begin errors++; $display("FAIL basic_no_repeat: got %b expected 0", tecla_valida); end
    $display("test_basic: tecla=%0d", tecla);
  endtask

  task automatic test_bounce();
    int s0;
    do_reset();
    s0 = subidas;
    forzar = 1'b1;
    for (int i = 0; i < 40; i++) begin
      filas_forz = (((i / 3) % 2) == 0) ? 4'b1110 : 4'b1111;
      @(negedge clk);
    end
    filas_forz = 4'b1111;
    repeat (60) @(negedge clk);
    checks++; if (subidas - s0 != 0) begin errors++; $display("FAIL bounce_codes: got %0d codes expected 0", subidas - s0); end
    checks++; if (tecla_valida !== 1'b0) begin errors++; $display("FAIL bounce_valida: got %b expected 0", tecla_valida); end
    checks++; if (presionada !== 1'b0) begin errors++; $display("FAIL bounce_presionada: got %b expected 0", presionada); end
    forzar = 1'b0;
    $display("test_bounce: codes=%0d", subidas - s0);
  endtask

  task automatic test_hold();
    int s0, k;
    do_reset();
    s0 = subidas;
    teclas[15] = 1'b1;
    repeat (300) @(negedge clk);
    checks++; if (subidas - s0 != 1) begin errors++; $display("FAIL hold_once: got %0d codes expected 1", subidas - s0); end
    checks++; if (tecla !== 4'd15) begin errors++; $display("FAIL hold_tecla: got %0d expected 15", tecla); end
    checks++; if (presionada !== 1'b1) begin errors++; $display("FAIL hold_presionada: got %b expected 1", presionada); end
    tecla_leida = 1'b1; @(negedge clk); tecla_leida = 1'b0;
    teclas = '0;
    repeat (20) @(negedge clk);
    checks++; if (presionada !== 1'b0) begin errors++; $display("FAIL hold_release: got %b expected 0", presionada); end
    teclas[15] = 1'b1;
    for (k = 0; k < 200; k++) begin @(negedge clk); if (presionada) break; end
    repeat (2) @(negedge clk);
    checks++; if (subidas - s0 != 2) begin errors++; $display("FAIL hold_repress: got %0d codes expected 2", subidas - s0); end
    checks++; if (tecla !== 4'd15) begin errors++; $display("FAIL hold_tecla2: got %0d expected 15", tecla); end
    teclas = '0;
    $display("test_hold: codes=%0d tecla=%0d", subidas - s0, tecla);
  endtask

  task automatic test_ghost();
    int oh, ln, ord, tr, s0;
    do_reset();
    s0 = subidas;
    forzar = 1'b1; filas_forz = 4'b0011;
    observar_barrido(48, oh, ln, ord, tr);
    checks++; if (ln != 0 || ord != 0 || oh != 0) begin errors++; $display("FAIL ghost_scan: got dwell=%0d order=%0d onehot=%0d expected 0/0/0", ln, ord, oh); end
    checks++; if (tr < 11) begin errors++; $display("FAIL ghost_progress: got %0d steps expected >=11", tr); end
    checks++; if (subidas - s0 != 0 || tecla_valida !== 1'b0) begin errors++; $display("FAIL ghost_codes: got %0d codes expected 0", subidas - s0); end
    forzar = 1'b0;
    $display("test_ghost: steps=%0d", tr);
  endtask

  task automatic test_overflow();
    int k;
    do_reset();
    teclas[0] = 1'b1;
    for (k = 0; k < 200; k++) begin @(negedge clk); if (presionada) break; end
    checks++; if (tecla !== 4'd0 || tecla_valida !== 1'b1) begin errors++; $display("FAIL ovf_first: got tecla=%0d valida=%b expected 0/1", tecla, tecla_valida); end
    teclas = '0;
    for (k = 0; k < 200; k++) begin @(negedge clk); if (!presionada) break; end
    teclas[5] = 1'b1;
    for (k = 0; k < 200; k++) begin @(negedge clk); if (presionada) break; end
    checks++; if (presionada !== 1'b1) begin errors++; $display("FAIL ovf_press: got %b expected 1", presionada); end
    checks++; if (tecla !== 4'd0) begin errors++; $display("FAIL ovf_tecla: got %0d expected 0", tecla); end
    checks++; if (desborde !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", desborde); end
    teclas = '0;
    repeat (30) @(negedge clk);
    checks++; if (desborde !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", desborde); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if (desborde !== 1'b0 || tecla !== 4'd0 || tecla_valida !== 1'b0 || presionada !== 1'b0 || columnas !== 4'b0111)
      begin errors++; $display("FAIL ovf_reset: got d=%b t=%0d v=%b p=%b c=%b expected 0/0/0/0/0111", desborde, tecla, tecla_valida, presionada, columnas); end
    $display("test_overflow: done");
  endtask

  task automatic test_rst_rebote();
    int k, s0;
    do_reset();
    teclas[2] = 1'b1;
    for (k = 0; k < 100; k++) begin @(negedge clk); if (columnas == 4'b1101) break; end
    repeat (6) @(negedge clk);
    checks++; if (columnas !== 4'b1101 || presionada !== 1'b0) begin errors++; $display("FAIL rstreb_debouncing: got c=%b p=%b expected 1101/0", columnas, presionada); end
    rst = 1'b1; teclas = '0;
    @(negedge clk);
    rst = 1'b0;
    s0 = subidas;
    checks++; if (columnas !== 4'b0111) begin errors++; $display("FAIL rstreb_columna: got %b expected 0111", columnas); end
    repeat (100) @(negedge clk);
    checks++; if (subidas - s0 != 0 || tecla_valida !== 1'b0 || tecla !== 4'd0) begin errors++; $display("FAIL rstreb_no_code: got codes=%0d tecla=%0d expected 0/0", subidas - s0, tecla); end
    $display("test_rst_rebote: done");
  endtask

  // Random presses with random hold and random acknowledge, checked against a
  // pending/overflow model of the handshake.
  task automatic test_random();
    int k, codigo;
    logic m_pend, m_desb;
    logic [3:0] m_tecla;
    do_reset();
    m_pend = 1'b0; m_desb = 1'b0; m_tecla = 4'd0;
    for (int it = 0; it < 10; it++) begin
      codigo = $urandom_range(0, 15);
      teclas = '0; teclas[codigo] = 1'b1;
      for (k = 0; k < 200; k++) begin @(negedge clk); if (presionada) break; end
      checks++; if (presionada !== 1'b1) begin errors++; $display("FAIL rand_press: key %0d not accepted", codigo); end
      if (!m_pend) begin m_tecla = 4'(codigo); m_pend = 1'b1; end
      else m_desb = 1'b1;
      repeat ($urandom_range(0, 40)) @(negedge clk);
      checks++;
      if (tecla !== m_tecla || tecla_valida !== m_pend || desborde !== m_desb) begin
        errors++;
        $display("FAIL rand_outputs: got t=%0d v=%b d=%b expected t=%0d v=%b d=%b", tecla, tecla_valida, desborde, m_tecla, m_pend, m_desb);
      end
      if ($urandom_range(0, 2) != 0) begin
        tecla_leida = 1'b1; @(negedge clk); tecla_leida = 1'b0;
        m_pend = 1'b0;
        checks++; if (tecla_valida !== 1'b0) begin errors++; $display("FAIL rand_ack: got %b expected 0", tecla_valida); end
      end
      teclas = '0;
      for (k = 0; k < 200; k++) begin @(negedge clk); if (!presionada) break; end
      checks++; if (presionada !== 1'b0) begin errors++; $display("FAIL rand_release: key %0d still pressed", codigo); end
      $display("test_random: key=%0d tecla=%0d valida=%b desborde=%b", codigo, tecla, tecla_valida, desborde);
    end
  endtask

  initial begin
    rst = 1'b1; teclas = '0; forzar = 1'b0; filas_forz = 4'hF; tecla_leida = 1'b0;
    test_reset();
    test_scan();
    test_basic();
    test_bounce();
    test_hold();
    test_ghost();
    test_overflow();
    test_rst_rebote();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/escaner_teclado.md
ESCANER_TECLADO -- requirements
Module: escaner_teclado

Interface
REQ-001 SHALL have parameter N_FILAS, default 4, number of keypad rows.
REQ-002 SHALL have parameter N_COLS, default 4, number of keypad columns.
REQ-003 SHALL have parameter CICLOS_COL, default 1000, clocks each column is driven before rows are sampled; values below 3 SHALL be rejected at elaboration.
REQ-004 SHALL have parameter CICLOS_REBOTE, default 100000, consecutive stable clocks required for press or release.
REQ-005 SHALL derive localparam CODE_W = $clog2(N_FILAS*N_COLS).
REQ-006 clk  input  1  system clock; single clock domain.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 filas  input  N_FILAS  row lines, active low, asynchronous to clk.
REQ-009 columnas  output  N_COLS  column drive, active low, exactly one bit low at all times.
REQ-010 tecla  output  CODE_W  code of last accepted key.
REQ-011 tecla_valida  output  1  code pending; held until read.
REQ-012 tecla_leida  input  1  consumer acknowledge, sampled on rising clk.
REQ-013 presionada  output  1  level, high from press acceptance until release acceptance.
REQ-014 desborde  output  1  sticky overflow flag.

Function
REQ-015 SHALL pass filas through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-016 Key code SHALL be fila*N_COLS + col, fila/col being the index of the low bit (bit N-1 = index 0, matching MSB-first scan order).
REQ-017 FSM states: ESCANEO, REBOTE, PRESIONADA, LIBERACION.
REQ-018 ESCANEO: drive column c for CICLOS_COL clocks; on last dwell clock sample rows: exactly one low -> latch fila/col, go REBOTE holding c; none low or >1 low (ghost) -> c advances, N_COLS-1 wraps to 0.
REQ-019 REBOTE: count clocks while sampled rows equal latched pattern; any change -> ESCANEO with next column, no code; count reaching CICLOS_REBOTE -> accept key, go PRESIONADA.
REQ-020 On acceptance tecla and tecla_valida SHALL update on the following rising edge; presionada rises on the same edge.
REQ-021 PRESIONADA: hold column; rows all high -> LIBERACION, counter cleared.
REQ-022 LIBERACION: rows all high for CICLOS_REBOTE consecutive clocks -> presionada falls, ESCANEO with next column; any row low before that -> PRESIONADA, no new code.
REQ-023 A held key SHALL produce exactly one code regardless of hold duration.
REQ-024 tecla_leida high while tecla_valida high -> tecla_valida low next edge; tecla_leida while tecla_valida low ignored.
REQ-025 Acceptance while tecla_valida high and tecla_leida low -> tecla keeps old code, desborde set, stays set until rst.
REQ-026 Acceptance and tecla_leida on same edge -> new code loaded, tecla_valida stays high, desborde unchanged.
REQ-027 Debounce and dwell counters SHALL be sized $clog2(max+1) and never wrap.

Reset
REQ-028 On rst high at rising clk: state ESCANEO, c=0 (columnas = 0 on bit N_COLS-1, others 1), tecla=0, tecla_valida=0, presionada=0, desborde=0, counters and synchronizer cleared to idle (rows all high).
REQ-029 rst mid-REBOTE/PRESIONADA/LIBERACION SHALL abandon the key with no code emitted.

Structure
REQ-030 Shared package teclado_pkg SHALL hold the state enum, default parameter constants, and a function mapping 4x4 code to hex digit (1,2,3,A/4,5,6,B/7,8,9,C/*,0,#,D -> unique 4-bit values, *=E, #=F).
REQ-031 Synchronizer SHALL be sub-module sincronizador, parameter ANCHO, reset value all ones.

Verification (bench params 4x4, CICLOS_COL=4, CICLOS_REBOTE=8)
REQ-032 Hold filas=1011 while columnas=1101 active -> tecla=6, tecla_valida=1, presionada=1; pulse tecla_leida -> tecla_valida=0 next edge.
REQ-033 filas toggles 1110/1111 every 3 clocks for 40 clocks, then 1111 -> tecla_valida never rises.
REQ-034 Key fila3 col3 held 300 clocks -> exactly one valid, tecla=15; release 20 clocks, repress -> second valid.
REQ-035 filas=0011 (two rows) in any column -> no code, scan continues wrapping 0..3.
REQ-036 Accept 1 (code 0), no ack, accept 5 (code 5) -> tecla=0, desborde=1; rst -> all outputs at REQ-028 values.
REQ-037 rst asserted during REBOTE -> after release of rst no code for that press, columnas restarts at column 0.
